// File: rtl/rtc_alarm.sv
// rtc_alarm: alarm stage that sits after the real-time-clock counters.
//
// Keeps a settable alarm time and runs a DISARMED / ARMED / RINGING /
// SNOOZING state machine that drives the buzzer. All logic runs on the
// rising edge of CLOCK_50. rst is synchronous and active-high.
//
// Optional build macro: ALARM_BEEP_EN
//   defined   - while ringing, the buzzer sounds 1 s on / 1 s off,
//               starting with the "on" second.
//   undefined - the buzzer stays high for the whole ringing period.
//
// Ports:
//   CLOCK_50    in   system clock
//   rst         in   synchronous active-high reset
//   tick_1hz    in   one-cycle pulse, once per second
//   hour_count  in   [5:0] current hour   (0-23)
//   min_count   in   [5:0] current minute (0-59)
//   sec_count   in   [5:0] current second (0-59)
//   alarm_en    in   level, 1 = alarm enabled
//   set_strobe  in   pulse, load set_value into the alarm time
//   set_hour    in   with set_strobe: 1 = hour, 0 = minute
//   set_value   in   [5:0] value to load (out-of-range values are ignored)
//   dismiss     in   pulse, stop ringing or snoozing
//   snooze      in   pulse, snooze while ringing
//   buzzer      out  alarm sound drive
//   armed       out  1 when the state is not DISARMED
//   snoozing    out  1 when the state is SNOOZING
//   alarm_hour  out  [5:0] stored alarm hour
//   alarm_min   out  [5:0] stored alarm minute
//
// state     | meaning
// ----------+------------------------------------------------------
// DISARMED  | alarm disabled, waiting for alarm_en
// ARMED     | waiting for the current time to reach the alarm time
// RINGING   | buzzer active, times out after RING_SECS seconds
// SNOOZING  | buzzer silent, re-rings after SNOOZE_SECS seconds

module rtc_alarm #(
  parameter int RING_SECS      = 60,
  parameter int SNOOZE_SECS    = 300,
  parameter int ALARM_HOUR_RST = 6,
  parameter int ALARM_MIN_RST  = 0
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [5:0] hour_count,
  input  logic [5:0] min_count,
  input  logic [5:0] sec_count,
  input  logic       alarm_en,
  input  logic       set_strobe,
  input  logic       set_hour,
  input  logic [5:0] set_value,
  input  logic       dismiss,
  input  logic       snooze,
  output logic       buzzer,
  output logic       armed,
  output logic       snoozing,
  output logic [5:0] alarm_hour,
  output logic [5:0] alarm_min
);

  // Width floor of 1 keeps the counters legal when a parameter is 1.
  localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SECS - 1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZING = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SW-1:0]   snz_cnt_q, snz_cnt_d;
  logic [5:0]      alarm_hour_q, alarm_hour_d;
  logic [5:0]      alarm_min_q, alarm_min_d;
  logic            match, match_q, match_rise;
  logic            buzzer_q, buzzer_d;
  logic            armed_q, snoozing_q;
`ifdef ALARM_BEEP_EN
  logic            beep_phase_q, beep_phase_d;
`endif

  assign match      = (hour_count == alarm_hour_q) && (min_count == alarm_min_q) &&
                      (sec_count == 6'd0);
  // Rising edge only: a held match (e.g. after dismiss in the same second)
  // cannot re-trigger.
  assign match_rise = match & ~match_q;

  always_comb begin
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    if (set_strobe) begin
      if (set_hour) begin
        if (set_value <= 6'd23) alarm_hour_d = set_value;
      end else begin
        if (set_value <= 6'd59) alarm_min_d = set_value;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!alarm_en) begin
      state_d    = ST_DISARMED;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_DISARMED: state_d = ST_ARMED;
        ST_ARMED: begin
          if (match_rise) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
        ST_RINGING: begin
          if (dismiss) begin
            state_d = ST_ARMED;
          end else if (snooze) begin
            state_d   = ST_SNOOZING;
            snz_cnt_d = SNZ_LOAD;
          end else if (tick_1hz) begin
            if (ring_cnt_q == RING_LAST) state_d = ST_ARMED;
            else ring_cnt_d = ring_cnt_q + RW'(1);
          end
        end
        ST_SNOOZING: begin
          if (dismiss) begin
            state_d = ST_ARMED;
          end else if (tick_1hz) begin
            if (snz_cnt_q == '0) begin
              state_d    = ST_RINGING;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q - SW'(1);
            end
          end
        end
        default: state_d = ST_DISARMED;
      endcase
    end
  end

`ifdef ALARM_BEEP_EN
  always_comb begin
    beep_phase_d = beep_phase_q;
    if (state_d == ST_RINGING && state_q != ST_RINGING)
      beep_phase_d = 1'b1;
    else if (state_q == ST_RINGING && state_d == ST_RINGING && tick_1hz)
      beep_phase_d = ~beep_phase_q;
  end
  assign buzzer_d = (state_d == ST_RINGING) & beep_phase_d;
`else
  assign buzzer_d = (state_d == ST_RINGING);
`endif

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q      <= ST_DISARMED;
      ring_cnt_q   <= '0;
      snz_cnt_q    <= '0;
      match_q      <= 1'b0;
      alarm_hour_q <= 6'(ALARM_HOUR_RST);
      alarm_min_q  <= 6'(ALARM_MIN_RST);
      buzzer_q     <= 1'b0;
      armed_q      <= 1'b0;
      snoozing_q   <= 1'b0;
`ifdef ALARM_BEEP_EN
      beep_phase_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      match_q      <= match;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      buzzer_q     <= buzzer_d;
      armed_q      <= (state_d != ST_DISARMED);
      snoozing_q   <= (state_d == ST_SNOOZING);
`ifdef ALARM_BEEP_EN
      beep_phase_q <= beep_phase_d;
`endif
    end
  end

  assign buzzer     = buzzer_q;
  assign armed      = armed_q;
  assign snoozing   = snoozing_q;
  assign alarm_hour = alarm_hour_q;
  assign alarm_min  = alarm_min_q;

endmodule

// File: tb/tb_rtc_alarm.sv
module tb_rtc_alarm;

  localparam int RING_SECS   = 4;
  localparam int SNOOZE_SECS = 3;
`ifdef ALARM_BEEP_EN
  localparam bit BEEP = 1'b1;
`else
  localparam bit BEEP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tick_1hz, alarm_en, set_strobe, set_hour, dismiss, snooze;
  logic [5:0] hour_count, min_count, sec_count, set_value;
  logic       buzzer, armed, snoozing;
  logic [5:0] alarm_hour, alarm_min;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rtc_alarm #(
    .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS),
    .ALARM_HOUR_RST(6), .ALARM_MIN_RST(0)
  ) dut (
    .CLOCK_50(clk), .rst(rst), .tick_1hz(tick_1hz),
    .hour_count(hour_count), .min_count(min_count), .sec_count(sec_count),
    .alarm_en(alarm_en), .set_strobe(set_strobe), .set_hour(set_hour),
    .set_value(set_value), .dismiss(dismiss), .snooze(snooze),
    .buzzer(buzzer), .armed(armed), .snoozing(snoozing),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min)
  );

  typedef struct {
    logic       en, ss, sh;
    logic [5:0] sv, h, m, s;
    logic       tk, dis, snz;
    logic       eb, ea, es;
    logic [5:0] eh, em;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic ss, logic sh, int sv, int h, int m, int s,
                              logic tk, logic dis, logic snz,
                              logic eb, logic ea, logic es, int eh, int em);
    vec_t v;
    v.en = en; v.ss = ss; v.sh = sh; v.sv = 6'(sv);
    v.h = 6'(h); v.m = 6'(m); v.s = 6'(s);
    v.tk = tk; v.dis = dis; v.snz = snz;
    v.eb = eb; v.ea = ea; v.es = es; v.eh = 6'(eh); v.em = 6'(em);
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    tick_1hz = 0; set_strobe = 0; set_hour = 0; set_value = 0; dismiss = 0; snooze = 0;
  endtask

  task automatic set_time(int h, int m, int s);
    hour_count = 6'(h); min_count = 6'(m); sec_count = 6'(s);
  endtask

  task automatic chk_outs(string name, logic eb, logic ea, logic es, int eh, int em);
    chk({name, ".buzzer"}, int'(buzzer), int'(eb));
    chk({name, ".armed"}, int'(armed), int'(ea));
    chk({name, ".snoozing"}, int'(snoozing), int'(es));
    chk({name, ".alarm_hour"}, int'(alarm_hour), eh);
    chk({name, ".alarm_min"}, int'(alarm_min), em);
  endtask

  // Ring the alarm by loading the minute equal to a current hh:mm:00.
  task automatic ring_at(int m);
    idle_in(); set_time(7, m, 0);
    step();
    set_strobe = 1; set_hour = 0; set_value = 6'(m);
    step();
    idle_in();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi_cnt;
    rst = 1; alarm_en = 0; idle_in(); set_time(7, 29, 59);

    // Fill the directed vector table.
    vecs.push_back(mk(0,1,1,24, 7,29,59, 0,0,0, 0,0,0, 6, 0));  // invalid hour
    vecs.push_back(mk(0,1,0,60, 7,29,59, 0,0,0, 0,0,0, 6, 0));  // invalid minute
    vecs.push_back(mk(1,0,0, 0, 7,29,59, 0,0,0, 0,1,0, 6, 0));  // arm
    vecs.push_back(mk(1,1,1, 7, 7,29,59, 0,0,0, 0,1,0, 7, 0));
    vecs.push_back(mk(1,1,0,30, 7,29,59, 0,0,0, 0,1,0, 7,30));
    vecs.push_back(mk(1,0,0, 0, 7,30, 0, 0,0,0, 1,1,0, 7,30));  // match rise
    vecs.push_back(mk(1,0,0, 0, 7,30, 0, 0,0,0, 1,1,0, 7,30));
    vecs.push_back(mk(1,0,0, 0, 7,30, 0, 0,1,0, 0,1,0, 7,30));  // dismiss
    vecs.push_back(mk(1,0,0, 0, 7,30, 0, 0,0,0, 0,1,0, 7,30));  // no re-trigger
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 0,0,0, 0,1,0, 7,30));
    vecs.push_back(mk(1,1,0,31, 7,31, 0, 0,0,0, 0,1,0, 7,31));  // load = now
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 0,0,0, 1,1,0, 7,31));
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 0,0,1, 0,1,1, 7,31));  // snooze
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 1,0,0, 0,1,1, 7,31));  // tick 1
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 0,0,0, 0,1,1, 7,31));
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 1,0,0, 0,1,1, 7,31));  // tick 2
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 0,0,1, 0,1,1, 7,31));  // snooze ignored
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 1,0,0, 1,1,0, 7,31));  // tick 3 -> ring
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 0,0,0, 1,1,0, 7,31));
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 1,0,0, !BEEP,1,0, 7,31)); // ring tick 1
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 0,0,0, !BEEP,1,0, 7,31));
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 1,0,0, 1,1,0, 7,31));     // ring tick 2
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 1,0,0, !BEEP,1,0, 7,31)); // ring tick 3
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 1,0,0, 0,1,0, 7,31));     // ring tick 4: timeout
    vecs.push_back(mk(1,0,0, 0, 7,31, 0, 0,0,0, 0,1,0, 7,31));
    vecs.push_back(mk(1,0,0, 0, 7,32, 0, 0,0,0, 0,1,0, 7,31));
    vecs.push_back(mk(1,1,0,32, 7,32, 0, 0,0,0, 0,1,0, 7,32));
    vecs.push_back(mk(1,0,0, 0, 7,32, 0, 0,0,0, 1,1,0, 7,32));     // ringing
    vecs.push_back(mk(0,0,0, 0, 7,32, 0, 0,0,0, 0,0,0, 7,32));     // disable mid-ring
    vecs.push_back(mk(1,0,0, 0, 7,32, 0, 0,0,0, 0,1,0, 7,32));     // re-arm, held match

    // Reset state.
    step(); step();
    chk_outs("reset", 0, 0, 0, 6, 0);
    rst = 0;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      alarm_en = v.en; set_strobe = v.ss; set_hour = v.sh; set_value = v.sv;
      set_time(int'(v.h), int'(v.m), int'(v.s));
      tick_1hz = v.tk; dismiss = v.dis; snooze = v.snz;
      step();
      chk_outs($sformatf("vec%0d", i), v.eb, v.ea, v.es, int'(v.eh), int'(v.em));
    end

    // Dismiss while the match is held for 1000 cycles.
    ring_at(33);
    chk("ring33.buzzer", int'(buzzer), 1);
    dismiss = 1;
    step();
    dismiss = 0;
    chk("dismiss33.buzzer", int'(buzzer), 0);
    hi_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (buzzer) hi_cnt++;
    end
    chk("hold1000.buzzer_high_cycles", hi_cnt, 0);
    chk("hold1000.armed", int'(armed), 1);
    chk("hold1000.snoozing", int'(snoozing), 0);

    // Reset while snoozing.
    ring_at(34);
    chk("ring34.buzzer", int'(buzzer), 1);
    snooze = 1;
    step();
    snooze = 0;
    chk("snooze34.snoozing", int'(snoozing), 1);
    chk("snooze34.buzzer", int'(buzzer), 0);
    rst = 1;
    step();
    chk_outs("rst_snooze", 0, 0, 0, 6, 0);
    rst = 0;
    step();
    chk("post_rst.armed", int'(armed), 1);
    chk("post_rst.buzzer", int'(buzzer), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
